magnitude_sqrt_iter: RTL and testbench
======================================

# magnitude_sqrt_iter

Parametrised, iterative integer square-root unit for the magnitude datapath: computes floor or rounded sqrt(sqrx + sqry) over a valid/ready handshake. It resolves one root bit per clock instead of the full combinational loop, and adds remainder output, optional round-to-nearest and back-pressure. It sits between the squaring stage and the downstream magnitude consumer.

## Interface
- `IN_W`, default 17: width of each squared operand.
- `SUM_W`, derived as `IN_W+1`: width of the operand sum. Not overridable.
- `ROOT_W`, derived as `(SUM_W+1)/2`, which is 9 at default: root width. Not overridable.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operands valid.
- `in_ready`  out  1  unit can accept operands.
- `sqrx`  in  IN_W  x².
- `sqry`  in  IN_W  y².
- `round_en`  in  1  1 selects round-to-nearest, 0 selects floor. Sampled with the operands.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `magnitude`  out  ROOT_W  root.
- `remainder`  out  ROOT_W+1  sum − floor_root². Always the floor remainder, even when rounding.
- `saturated`  out  1  rounding was clamped to all-ones.

## Operation
- States:
  - IDLE: `in_ready`=1.
  - CALC: iterating.
  - DONE: `out_valid`=1.
- IDLE→CALC on `in_valid`&`in_ready`:
  - Latch sum = `sqrx`+`sqry` as a full SUM_W-bit sum, never truncated, zero-extended to 2·ROOT_W bits.
  - Latch `round_en`.
  - Clear root, rem and the iteration counter.
- Each CALC cycle, i from ROOT_W−1 down to 0:
  - rem = (rem<<2) | sum[2i+1:2i].
  - trial = (root<<2)|1.
  - If rem ≥ trial: rem −= trial and root = (root<<1)|1.
  - Otherwise root = root<<1.
  - rem is ROOT_W+2 bits wide; its final value never exceeds 2·root.
- CALC→DONE after exactly ROOT_W iterations. On entry to DONE:
  - `remainder` = rem.
  - If the latched round_en=1 and rem > root: `magnitude` = root+1, or all-ones with `saturated`=1 if root is already all-ones.
  - Otherwise `magnitude` = root and `saturated`=0.
- DONE→IDLE on `out_ready`.
- `magnitude`, `remainder` and `saturated` hold stable from `out_valid` rise until the handshake completes. After the handshake they keep their last value, and are don't-care to consumers.
- `in_valid` during CALC/DONE is ignored; `in_ready`=0, so there is no loss and the producer holds.
- `out_ready` outside DONE is ignored.
- Asserting `rst_n` low at any point:
  - Forces IDLE and aborts any in-flight operation; the result is discarded with no output.
  - `in_ready` returns to 1 on the first edge after release.

## Timing
- Reset values:
  - `in_ready`=1 (IDLE).
  - `out_valid`=0.
  - `magnitude`=0, `remainder`=0, `saturated`=0.
  - Internal state IDLE, counter 0.
- Acceptance edge = E:
  - CALC iterations occur on edges E+1…E+ROOT_W.
  - `out_valid` is high from after edge E+ROOT_W, so latency is ROOT_W edges (9 at default).
- Handshake edge H (`out_valid`&`out_ready`): `in_ready`=1 after H. The next accept is at H+1 at the earliest.
- Peak throughput: one result per ROOT_W+2 cycles.
- `in_ready` and `out_valid` are registered-state decodes only. There is no combinational path from any input to any output.

## Structure
- Package `magnitude_pkg`:
  - The state enum (IDLE/CALC/DONE).
  - A function computing ROOT_W from IN_W.
  - Shared by future magnitude blocks.
- Sub-module `sqrt_step`:
  - Purely combinational single iteration.
  - Inputs: root, rem, 2-bit digit. Outputs: next root, next rem.
  - Parametrised by ROOT_W.
  - Instantiated once, so the top holds only the FSM, counter and registers.

## Test plan
- sqrx=9, sqry=16, round_en=0 → after 9 edges: magnitude=5, remainder=0, saturated=0.
- sqrx=0, sqry=0 → magnitude=0, remainder=0. Then sqrx=131071, sqry=131071, round_en=0 → magnitude=511, remainder=1021.
- Same max operands with round_en=1 → magnitude=511, saturated=1, remainder=1021.
- Rounding boundary, round_en=1:
  - Sum 30 → magnitude=5, remainder=5.
  - Sum 31 → magnitude=6, remainder=6.
  - Sum 31 with round_en=0 → magnitude=5.
- Back-pressure: hold out_ready=0 for 5 cycles after out_valid → outputs and out_valid stable, in_ready=0, in_valid pulses ignored. Result is delivered on the out_ready edge, and in_ready=1 on the next cycle.
- Reset mid-CALC (pull rst_n low at iteration 4) → out_valid=0 and all outputs 0 immediately. After release: in_ready=1 and no stale result ever appears. A fresh sum of 144 gives 12.

Source files
------------

// File: rtl/magnitude_pkg.sv
// Shared types and helpers for the magnitude datapath.
// Root width derives from the squared-operand width.
package magnitude_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // sum is in_w+1 bits; root needs half of that, rounded up
  function automatic int root_w_of(input int in_w);
    return (in_w + 2) / 2;
  endfunction

endpackage

// File: rtl/sqrt_step.sv
// One restoring square-root iteration: resolves one root bit
// from the running remainder and the next radicand digit pair.
module sqrt_step #(
  parameter int ROOT_W = 9
) (
  input  logic [ROOT_W-1:0] root_i,
  input  logic [ROOT_W+1:0] rem_i,
  input  logic [1:0]        digit_i,
  output logic [ROOT_W-1:0] root_o,
  output logic [ROOT_W+1:0] rem_o
);

  logic [ROOT_W+1:0] rem_sh;
  logic [ROOT_W+1:0] trial;
  logic              ge;

  // rem stays below 2*root, so its top bits are zero before the shift
  always_comb begin
    rem_sh = (ROOT_W+2)'({rem_i, digit_i});
    trial  = {root_i, 2'b01};
    ge     = rem_sh >= trial;
    rem_o  = ge ? rem_sh - trial : rem_sh;
    root_o = ROOT_W'({root_i, ge});
  end

endmodule

// File: rtl/magnitude_sqrt_iter.sv
// Iterative integer sqrt(sqrx + sqry), one root bit per clock,
// with floor remainder, optional rounding and back-pressure.
module magnitude_sqrt_iter
  import magnitude_pkg::*;
#(
  parameter int IN_W = 17
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [IN_W-1:0]          sqrx,
  input  logic [IN_W-1:0]          sqry,
  input  logic                     round_en,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [root_w_of(IN_W)-1:0] magnitude,
  output logic [root_w_of(IN_W):0] remainder,
  output logic                     saturated
);

  localparam int SUM_W  = IN_W + 1;
  localparam int ROOT_W = root_w_of(IN_W);
  localparam int RAD_W  = 2 * ROOT_W;
  localparam int CNT_W  = $clog2(ROOT_W + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ROOT_W - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [RAD_W-1:0]    sum_q, sum_d;
  logic                rnd_q, rnd_d;
  logic [ROOT_W-1:0]   root_q, root_d;
  logic [ROOT_W+1:0]   rem_q, rem_d;
  logic [ROOT_W-1:0]   mag_q, mag_d;
  logic [ROOT_W:0]     remd_q, remd_d;
  logic                sat_q, sat_d;

  logic [SUM_W-1:0]    add;
  logic [ROOT_W-1:0]   step_root;
  logic [ROOT_W+1:0]   step_rem;

  // radicand is consumed MSB digit-pair first by shifting left
  sqrt_step #(.ROOT_W(ROOT_W)) u_step (
    .root_i  (root_q),
    .rem_i   (rem_q),
    .digit_i (sum_q[RAD_W-1 -: 2]),
    .root_o  (step_root),
    .rem_o   (step_rem)
  );

  assign add       = SUM_W'(sqrx) + SUM_W'(sqry);
  assign in_ready  = state_q == ST_IDLE;
  assign out_valid = state_q == ST_DONE;
  assign magnitude = mag_q;
  assign remainder = remd_q;
  assign saturated = sat_q;

  // FSM, iteration datapath and result capture with rounding
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    rnd_d   = rnd_q;
    root_d  = root_q;
    rem_d   = rem_q;
    mag_d   = mag_q;
    remd_d  = remd_q;
    sat_d   = sat_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_CALC;
          sum_d   = RAD_W'(add);
          rnd_d   = round_en;
          root_d  = '0;
          rem_d   = '0;
          cnt_d   = '0;
        end
      end
      ST_CALC: begin
        root_d = step_root;
        rem_d  = step_rem;
        sum_d  = sum_q << 2;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = ST_DONE;
          remd_d  = (ROOT_W+1)'(step_rem);
          mag_d   = step_root;
          sat_d   = 1'b0;
          if (rnd_q && step_rem > {2'b00, step_root}) begin
            if (&step_root) sat_d = 1'b1;
            else            mag_d = step_root + 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // state registers; reset aborts any in-flight operation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sum_q   <= '0;
      rnd_q   <= 1'b0;
      root_q  <= '0;
      rem_q   <= '0;
      mag_q   <= '0;
      remd_q  <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      rnd_q   <= rnd_d;
      root_q  <= root_d;
      rem_q   <= rem_d;
      mag_q   <= mag_d;
      remd_q  <= remd_d;
      sat_q   <= sat_d;
    end
  end

endmodule

// File: tb/tb_magnitude_sqrt_iter.sv
// Directed checks for the iterative magnitude square root.
// Expected roots and remainders are hand-computed.
module tb_magnitude_sqrt_iter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [16:0] sqrx = '0;
  logic [16:0] sqry = '0;
  logic        round_en = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [8:0]  magnitude;
  logic [9:0]  remainder;
  logic        saturated;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  magnitude_sqrt_iter #(.IN_W(17)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sqrx      (sqrx),
    .sqry      (sqry),
    .round_en  (round_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .magnitude (magnitude),
    .remainder (remainder),
    .saturated (saturated)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic do_op(input string tag, input logic [16:0] x,
                       input logic [16:0] y, input logic rnd,
                       input int em, input int er, input int es,
                       input int hold);
    int n;
    chk({tag, ".rdy0"}, in_ready, 1);
    in_valid = 1'b1;
    sqrx = x;
    sqry = y;
    round_en = rnd;
    @(posedge clk); #1;
    in_valid = 1'b0;
    sqrx = '0;
    sqry = '0;
    round_en = ~rnd;
    chk({tag, ".busy"}, in_ready, 0);
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, ".lat"}, n, 9);
    chk({tag, ".mag"}, magnitude, em);
    chk({tag, ".rem"}, remainder, er);
    chk({tag, ".sat"}, saturated, es);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      sqrx = 17'd4;
      @(posedge clk); #1;
      chk({tag, ".bp_v"}, out_valid, 1);
      chk({tag, ".bp_r"}, in_ready, 0);
      chk({tag, ".bp_m"}, magnitude, em);
      chk({tag, ".bp_e"}, remainder, er);
    end
    in_valid = 1'b0;
    sqrx = '0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, ".hs_v"}, out_valid, 0);
    chk({tag, ".hs_r"}, in_ready, 1);
  endtask

  initial begin
    int stale;
    #2;
    chk("rst.rdy", in_ready, 1);
    chk("rst.v", out_valid, 0);
    chk("rst.mag", magnitude, 0);
    chk("rst.rem", remainder, 0);
    chk("rst.sat", saturated, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op("p25", 17'd9, 17'd16, 1'b0, 5, 0, 0, 0);
    do_op("zero", 17'd0, 17'd0, 1'b0, 0, 0, 0, 0);
    do_op("maxf", 17'd131071, 17'd131071, 1'b0, 511, 1021, 0, 0);
    do_op("maxr", 17'd131071, 17'd131071, 1'b1, 511, 1021, 1, 0);
    do_op("s30r", 17'd14, 17'd16, 1'b1, 5, 5, 0, 5);
    do_op("s31r", 17'd15, 17'd16, 1'b1, 6, 6, 0, 0);
    do_op("s31f", 17'd15, 17'd16, 1'b0, 5, 6, 0, 0);
    do_op("big", 17'd60000, 17'd40000, 1'b0, 316, 144, 0, 0);

    in_valid = 1'b1;
    sqrx = 17'd65000;
    sqry = 17'd65000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("ab.v", out_valid, 0);
    chk("ab.mag", magnitude, 0);
    chk("ab.rem", remainder, 0);
    chk("ab.rdy", in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ab.rdy1", in_ready, 1);
    stale = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (out_valid) stale++;
    end
    chk("ab.stale", stale, 0);
    do_op("p144", 17'd0, 17'd144, 1'b0, 12, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
